data_mem_pipe: RTL

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pkg.sv | 14 +
 rtl/data_mem_rd_pipe.sv | 43 ++++
 rtl/data_mem_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the pipelined data memory.
package data_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of byte-lane address bits for a given word width.
  function automatic int calc_lb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/data_mem_rd_pipe.sv
// Fixed-latency read delay line: valid bit plus data, STAGES registers deep.
module data_mem_rd_pipe #(
  parameter int STAGES     = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES:1]                 vld_pipe_d, vld_pipe_q;
  logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe_d, dat_pipe_q;

  // Data only moves with its valid bit, so the last stage holds the
  // most recently delivered word between pulses.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = in_vld;
    if (in_vld) dat_pipe_d[1] = in_data;
    for (int i = 2; i <= STAGES; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign out_vld  = vld_pipe_q[STAGES];
  assign out_data = dat_pipe_q[STAGES];

endmodule

// File: rtl/data_mem_pipe.sv
// Single-port byte-writable data memory with self-clearing init and a
// fully pipelined fixed-latency read path.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    write_enable,
  input  logic                    mem_read,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    ready,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    addr_error
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = calc_lb(DATA_WIDTH);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((64'd1 << LB) - 64'd1);

  state_e        state_d, state_q;
  logic [IW-1:0] clr_cnt_d, clr_cnt_q;
  logic          ready_d, ready_q;
  logic          addr_error_d, addr_error_q;

  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [IW-1:0]         word_idx;
  logic                  misaligned, both_req, wr_acc, rd_acc;
  logic                  unused_addr;

  logic                  mem_we;
  logic [IW-1:0]         mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Upper address bits beyond the word index are ignored (wrap modulo DEPTH).
  assign addr_sh     = addr >> LB;
  assign word_idx    = addr_sh[IW-1:0];
  assign unused_addr = ^addr_sh;

  assign misaligned = |(addr & LANE_MASK);
  assign both_req   = write_enable & mem_read;
  assign wr_acc     = ready_q & write_enable & ~mem_read & ~misaligned;
  assign rd_acc     = ready_q & mem_read & ~write_enable & ~misaligned;

  always_comb begin
    addr_error_d = ready_q & (both_req | ((write_enable | mem_read) & misaligned));
  end

  // Control FSM: walk every word to zero, then open for requests.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IW'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      clr_cnt_q    <= '0;
      ready_q      <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ready_q      <= ready_d;
      addr_error_q <= addr_error_d;
    end
  end

  // One write port shared between the init sweep and accepted writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = word_idx;
    mem_wdat = write_data;
    mem_be   = byte_en;
    if (!rst) begin
      if (state_q == INIT) begin
        mem_we   = 1'b1;
        mem_widx = clr_cnt_q;
        mem_wdat = '0;
        mem_be   = '1;
      end else if (wr_acc) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  data_mem_rd_pipe #(
    .STAGES     (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc & ~rst),
    .in_data  (mem_q[word_idx]),
    .out_vld  (read_valid),
    .out_data (read_data)
  );

  assign ready      = ready_q;
  assign addr_error = addr_error_q;

endmodule
